// File: rtl/icache_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : icache_controller
// Description : Sequencing FSM for a direct-mapped, one-word-per-line
//               instruction cache. Accepts CPU fetches and probes the storage
//               compare port. On a miss it fetches the word from next-level
//               memory over valid/ready, refills the line and forwards the
//               word to the CPU. Also supports whole-cache flush and keeps
//               saturating hit/miss counters.
// Ports       : clk, reset (sync, active-low)
//               CPU    : cpu_req_valid/cpu_addr/cpu_req_ready,
//                        cpu_resp_valid/cpu_rdata, flush, busy
//               Storage: COMPARE_EN/ADDRESS/HIT/READDATA,
//                        WRITE_ENABLE/WRITE_ADDRESS/WRITEDATA/WRITETAG/WRITEVALID
//               Memory : mem_req_valid/mem_req_ready/mem_addr,
//                        mem_resp_valid/mem_rdata
//               Perf   : hit_count, miss_count
// Revision    : 1.0 - initial release
// ============================================================================
module icache_controller #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5,
    parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req_valid,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic                  cpu_req_ready,
    output logic                  cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  flush,
    output logic                  busy,
    output logic                  COMPARE_EN,
    output logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic                  HIT,
    input  logic [DATA_WIDTH-1:0] READDATA,
    output logic                  WRITE_ENABLE,
    output logic [ADDR_WIDTH-1:0] WRITE_ADDRESS,
    output logic [DATA_WIDTH-1:0] WRITEDATA,
    output logic [TAG_WIDTH-1:0]  WRITETAG,
    output logic                  WRITEVALID,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COMPARE   = 3'd1,
        S_MISS_REQ  = 3'd2,
        S_MISS_WAIT = 3'd3,
        S_FLUSH     = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [INDEX_WIDTH-1:0] r_flush_idx;
    logic [CNT_WIDTH-1:0]   r_hit_count;
    logic [CNT_WIDTH-1:0]   r_miss_count;

    logic w_accept;
    logic w_hit_event;
    logic w_miss_event;

    // Flush wins over a simultaneous fetch; the fetch is dropped, not queued.
    assign w_accept     = (r_state == S_IDLE) && !flush && cpu_req_valid;
    assign w_hit_event  = (r_state == S_COMPARE) && HIT;
    assign w_miss_event = (r_state == S_COMPARE) && !HIT;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_flush_idx  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_addr <= cpu_addr;
            end
            if ((r_state == S_IDLE) && flush) begin
                r_flush_idx <= '0;
            end else if (r_state == S_FLUSH) begin
                // Wraps back to zero on the final line, ready for the next flush.
                r_flush_idx <= r_flush_idx + INDEX_WIDTH'(1);
            end
            if (w_hit_event && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + CNT_WIDTH'(1);
            end
            if (w_miss_event && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_next_state   = r_state;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_rdata      = '0;
        COMPARE_EN     = 1'b0;
        WRITE_ENABLE   = 1'b0;
        WRITE_ADDRESS  = r_addr;
        WRITEDATA      = '0;
        WRITETAG       = '0;
        WRITEVALID     = 1'b0;
        mem_req_valid  = 1'b0;

        case (r_state)
            S_IDLE: begin
                cpu_req_ready = 1'b1;
                if (flush) begin
                    w_next_state = S_FLUSH;
                end else if (cpu_req_valid) begin
                    w_next_state = S_COMPARE;
                end
            end
            S_COMPARE: begin
                COMPARE_EN = 1'b1;
                if (HIT) begin
                    cpu_resp_valid = 1'b1;
                    cpu_rdata      = READDATA;
                    w_next_state   = S_IDLE;
                end else begin
                    w_next_state   = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_next_state = S_MISS_WAIT;
                end
            end
            S_MISS_WAIT: begin
                // Refill and CPU response happen in the same cycle; the word
                // is forwarded straight from memory rather than re-read.
                if (mem_resp_valid) begin
                    WRITE_ENABLE   = 1'b1;
                    WRITEDATA      = mem_rdata;
                    WRITETAG       = r_addr[ADDR_WIDTH-1:INDEX_WIDTH];
                    WRITEVALID     = 1'b1;
                    cpu_resp_valid = 1'b1;
                    cpu_rdata      = mem_rdata;
                    w_next_state   = S_IDLE;
                end
            end
            S_FLUSH: begin
                WRITE_ENABLE  = 1'b1;
                WRITE_ADDRESS = {{TAG_WIDTH{1'b0}}, r_flush_idx};
                if (r_flush_idx == '1) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign busy       = (r_state != S_IDLE);
    assign ADDRESS    = r_addr;
    assign mem_addr   = r_addr;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_icache_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_icache_controller
// Description : Self-checking bench for icache_controller. Contains a simple
//               behavioural icache_storage, a bench-driven memory and a
//               request-level reference model of cache contents and counters.
//               Counters are narrowed so saturation is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_controller;

    localparam int c_AW  = 32;
    localparam int c_DW  = 32;
    localparam int c_IW  = 5;
    localparam int c_TW  = c_AW - c_IW;
    localparam int c_CW  = 4;
    localparam int c_NL  = 1 << c_IW;
    localparam int c_MAX = (1 << c_CW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            cpu_req_valid;
    logic [c_AW-1:0] cpu_addr;
    logic            cpu_req_ready;
    logic            cpu_resp_valid;
    logic [c_DW-1:0] cpu_rdata;
    logic            flush;
    logic            busy;
    logic            COMPARE_EN;
    logic [c_AW-1:0] ADDRESS;
    logic            HIT;
    logic [c_DW-1:0] READDATA;
    logic            WRITE_ENABLE;
    logic [c_AW-1:0] WRITE_ADDRESS;
    logic [c_DW-1:0] WRITEDATA;
    logic [c_TW-1:0] WRITETAG;
    logic            WRITEVALID;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [c_AW-1:0] mem_addr;
    logic            mem_resp_valid;
    logic [c_DW-1:0] mem_rdata;
    logic [c_CW-1:0] hit_count;
    logic [c_CW-1:0] miss_count;

    icache_controller #(
        .ADDR_WIDTH (c_AW),
        .DATA_WIDTH (c_DW),
        .INDEX_WIDTH(c_IW),
        .TAG_WIDTH  (c_TW),
        .CNT_WIDTH  (c_CW)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req_valid (cpu_req_valid),
        .cpu_addr      (cpu_addr),
        .cpu_req_ready (cpu_req_ready),
        .cpu_resp_valid(cpu_resp_valid),
        .cpu_rdata     (cpu_rdata),
        .flush         (flush),
        .busy          (busy),
        .COMPARE_EN    (COMPARE_EN),
        .ADDRESS       (ADDRESS),
        .HIT           (HIT),
        .READDATA      (READDATA),
        .WRITE_ENABLE  (WRITE_ENABLE),
        .WRITE_ADDRESS (WRITE_ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .WRITETAG      (WRITETAG),
        .WRITEVALID    (WRITEVALID),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata     (mem_rdata),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    // Behavioural storage: combinational compare, write on the clock edge.
    logic [c_NL-1:0] st_valid = '0;
    logic [c_TW-1:0] st_tag  [c_NL];
    logic [c_DW-1:0] st_data [c_NL];

    assign HIT      = COMPARE_EN && st_valid[ADDRESS[c_IW-1:0]]
                      && (st_tag[ADDRESS[c_IW-1:0]] == ADDRESS[c_AW-1:c_IW]);
    assign READDATA = st_data[ADDRESS[c_IW-1:0]];

    always @(posedge clk) begin
        if (WRITE_ENABLE) begin
            st_valid[WRITE_ADDRESS[c_IW-1:0]] <= WRITEVALID;
            st_tag[WRITE_ADDRESS[c_IW-1:0]]   <= WRITETAG;
            st_data[WRITE_ADDRESS[c_IW-1:0]]  <= WRITEDATA;
        end
    end

    // Reference model: what the cache should hold, per line.
    bit              ref_valid [c_NL];
    logic [c_TW-1:0] ref_tag   [c_NL];
    logic [c_DW-1:0] ref_data  [c_NL];
    int              ref_hits;
    int              ref_misses;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_fetch(input logic [c_AW-1:0] addr, input logic [c_DW-1:0] data,
                            input int rdly, input int wdly, input bit stray);
        int unsigned     idx;
        logic [c_TW-1:0] tg;
        bit              exp_hit;
        idx     = addr[c_IW-1:0];
        tg      = addr[c_AW-1:c_IW];
        exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
        check_eq("req_ready", cpu_req_ready, 1);
        cpu_req_valid = 1'b1;
        cpu_addr      = addr;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_addr      = $urandom;
        check_eq("cmp_addr", ADDRESS, addr);
        check_eq("resp_on_cmp", cpu_resp_valid, exp_hit);
        if (exp_hit) begin
            check_eq("hit_rdata", cpu_rdata, ref_data[idx]);
            ref_hits = (ref_hits < c_MAX) ? ref_hits + 1 : c_MAX;
            @(negedge clk);
            check_eq("hit_count", hit_count, ref_hits);
            check_eq("hit_idle", busy, 0);
            check_eq("hit_no_memreq", mem_req_valid, 0);
        end else begin
            ref_misses = (ref_misses < c_MAX) ? ref_misses + 1 : c_MAX;
            @(negedge clk);
            check_eq("miss_count", miss_count, ref_misses);
            check_eq("memreq_valid", mem_req_valid, 1);
            check_eq("memreq_addr", mem_addr, addr);
            for (int i = 0; i < rdly; i++) begin
                if (stray && i == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = ~data;
                    #1;
                    check_eq("stray_no_write", WRITE_ENABLE, 0);
                    check_eq("stray_no_resp", cpu_resp_valid, 0);
                end
                @(negedge clk);
                mem_resp_valid = 1'b0;
                check_eq("memreq_hold", mem_req_valid, 1);
                check_eq("memaddr_hold", mem_addr, addr);
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            check_eq("wait_no_memreq", mem_req_valid, 0);
            for (int i = 0; i < wdly; i++) begin
                check_eq("wait_no_resp", cpu_resp_valid, 0);
                @(negedge clk);
            end
            mem_resp_valid = 1'b1;
            mem_rdata      = data;
            #1;
            check_eq("refill_we", WRITE_ENABLE, 1);
            check_eq("refill_waddr", WRITE_ADDRESS, addr);
            check_eq("refill_tag", WRITETAG, tg);
            check_eq("refill_data", WRITEDATA, data);
            check_eq("refill_valid", WRITEVALID, 1);
            check_eq("miss_resp", cpu_resp_valid, 1);
            check_eq("miss_rdata", cpu_rdata, data);
            @(negedge clk);
            mem_resp_valid = 1'b0;
            check_eq("miss_idle", busy, 0);
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
            ref_data[idx]  = data;
        end
    endtask

    task automatic do_flush(input bit with_req);
        int cycles;
        flush         = 1'b1;
        cpu_req_valid = with_req;
        cpu_addr      = 32'h43;
        @(negedge clk);
        flush         = 1'b0;
        cpu_req_valid = 1'b0;
        cycles        = 0;
        while (busy && cycles < 40) begin
            check_eq("flush_we", WRITE_ENABLE, 1);
            check_eq("flush_waddr", WRITE_ADDRESS, cycles);
            check_eq("flush_wvalid", WRITEVALID, 0);
            check_eq("flush_no_resp", cpu_resp_valid, 0);
            cycles++;
            @(negedge clk);
        end
        check_eq("flush_len", cycles, c_NL);
        check_eq("flush_after_resp", cpu_resp_valid, 0);
        for (int i = 0; i < c_NL; i++) ref_valid[i] = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        cpu_req_valid  = 1'b0;
        cpu_addr       = '0;
        flush          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        ref_hits       = 0;
        ref_misses     = 0;
        for (int i = 0; i < c_NL; i++) ref_valid[i] = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_we", WRITE_ENABLE, 0);
        check_eq("rst_memreq", mem_req_valid, 0);
        check_eq("rst_resp", cpu_resp_valid, 0);
        check_eq("rst_hits", hit_count, 0);
        check_eq("rst_misses", miss_count, 0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", cpu_req_ready, 1);
        check_eq("post_rst_cmp", COMPARE_EN, 0);

        // Directed scenarios.
        do_fetch(32'h43, 32'hDEADBEEF, 0, 1, 1'b0);
        do_fetch(32'h43, 32'h0, 0, 0, 1'b0);
        check_eq("hit_count_1", hit_count, 1);
        do_fetch(32'h63, 32'h12345678, 1, 0, 1'b0);
        do_fetch(32'h43, 32'hDEADBEEF, 0, 2, 1'b0);
        check_eq("miss_count_3", miss_count, 3);
        do_fetch(32'h80, 32'hCAFEF00D, 5, 2, 1'b1);
        do_flush(1'b1);
        do_fetch(32'h43, 32'hA5A5A5A5, 0, 0, 1'b0);

        // Reset while waiting for memory: the late response must be ignored.
        cpu_req_valid = 1'b1;
        cpu_addr      = 32'h1234;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check_eq("abort_in_wait", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        reset          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hBAD0BAD0;
        #1;
        check_eq("abort_no_we", WRITE_ENABLE, 0);
        check_eq("abort_no_resp", cpu_resp_valid, 0);
        check_eq("abort_hits", hit_count, 0);
        check_eq("abort_misses", miss_count, 0);
        check_eq("abort_ready", cpu_req_ready, 1);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check_eq("abort_idle", busy, 0);
        ref_hits   = 0;
        ref_misses = 0;

        // Randomized traffic over a small tag pool so hits, conflicts and
        // counter saturation all occur.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                do_flush(1'($urandom_range(0, 1)));
            end else begin
                int rd;
                rd = $urandom_range(0, 3);
                do_fetch((32'($urandom_range(0, 3)) << c_IW) | 32'($urandom_range(0, c_NL - 1)),
                         $urandom, rd, $urandom_range(0, 3),
                         (rd > 0) && ($urandom_range(0, 1) == 1));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
